// File: rtl/comparator_tpi_bist.sv
// Comparator y = (a > b) & (c == d) with a control point, an observation
// port and LFSR/MISR BIST. Optional serial signature unload: SIG_SHIFT_EN.
module comparator_tpi_bist #(
  parameter int                    WIDTH     = 4,
  parameter logic [4*WIDTH-1:0]    LFSR_TAPS = 16'hB400,
  parameter logic [4*WIDTH-1:0]    LFSR_SEED = 16'hACE1,
  parameter int                    MISR_W    = 16,
  parameter logic [MISR_W-1:0]     MISR_TAPS = 16'hB400,
  parameter int                    NUM_PAT   = 255,
  parameter int                    CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [WIDTH-1:0]  c,
  input  logic [WIDTH-1:0]  d,
  input  logic              test_mode,
  input  logic [1:0]        tp_ctrl,
  input  logic              bist_start,
  output logic              y,
  output logic [1:0]        obs,
  output logic              bist_busy,
  output logic              bist_done,
  output logic [MISR_W-1:0] signature,
`ifdef SIG_SHIFT_EN
  input  logic              sig_shift,
  output logic              sig_so,
`endif
  output logic [CNT_W-1:0]  pattern_count
);

  localparam int LW = 4 * WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PAT - 1);

  if (NUM_PAT < 1 || NUM_PAT >= (1 << CNT_W)) begin : g_bad_num_pat
    $error("NUM_PAT must lie in 1..2^CNT_W-1");
  end
  if (MISR_W < 4) begin : g_bad_misr_w
    $error("MISR_W must be at least 4");
  end
  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [LW-1:0]     lfsr;
  logic [WIDTH-1:0]  op_a, op_b, op_c, op_d;
  logic              gt_ab, eq_cd, eq_int, y_comb;
  logic              force_en, force_val;
  logic [MISR_W-1:0] resp;
  logic [MISR_W-1:0] sig_next;
  logic [LW-1:0]     lfsr_next;
  logic              start_req;

  assign start_req = bist_start & test_mode;

`ifdef SIG_SHIFT_EN
  assign sig_so = signature[0];
`endif

  // Operand mux, compare nodes, control point and next BIST state
  always_comb begin
    op_a = a;
    op_b = b;
    op_c = c;
    op_d = d;
    force_en  = test_mode & tp_ctrl[1];
    force_val = tp_ctrl[0];
    if (state == RUN) begin
      op_a = lfsr[LW-1 -: WIDTH];
      op_b = lfsr[LW-WIDTH-1 -: WIDTH];
      op_c = lfsr[2*WIDTH-1 -: WIDTH];
      op_d = lfsr[WIDTH-1:0];
      force_en  = pattern_count[0];
      force_val = 1'b1;
    end
    gt_ab  = op_a > op_b;
    eq_cd  = op_c == op_d;
    eq_int = force_en ? force_val : eq_cd;
    y_comb = gt_ab & eq_int;
    resp      = '0;
    resp[3:0] = {gt_ab, eq_cd, eq_int, y_comb};
    sig_next  = (signature >> 1)
              ^ (signature[0] ? MISR_TAPS : '0)
              ^ resp;
    lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
  end

  // Registered outputs plus the IDLE/RUN/DONE BIST controller
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lfsr          <= LFSR_SEED;
      signature     <= '0;
      pattern_count <= '0;
      y             <= 1'b0;
      obs           <= 2'b00;
      bist_busy     <= 1'b0;
      bist_done     <= 1'b0;
    end else begin
      y   <= y_comb;
      obs <= {gt_ab, eq_cd};
      unique case (state)
        IDLE: begin
          if (start_req) begin
            state         <= RUN;
            lfsr          <= LFSR_SEED;
            signature     <= '0;
            pattern_count <= '0;
            bist_busy     <= 1'b1;
          end
        end
        RUN: begin
          if (!test_mode) begin
            state     <= IDLE;
            bist_busy <= 1'b0;
          end else begin
            signature     <= sig_next;
            lfsr          <= lfsr_next;
            pattern_count <= pattern_count + 1'b1;
            if (pattern_count == LAST) begin
              state     <= DONE;
              bist_busy <= 1'b0;
              bist_done <= 1'b1;
            end
          end
        end
        DONE: begin
          if (start_req) begin
            state         <= RUN;
            lfsr          <= LFSR_SEED;
            signature     <= '0;
            pattern_count <= '0;
            bist_busy     <= 1'b1;
            bist_done     <= 1'b0;
          end else if (!test_mode) begin
            state     <= IDLE;
            bist_done <= 1'b0;
          end
`ifdef SIG_SHIFT_EN
          else if (sig_shift) begin
            signature <= {1'b0, signature[MISR_W-1:1]};
          end
`endif
        end
        default: begin
          state     <= IDLE;
          bist_busy <= 1'b0;
          bist_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_tpi_bist.sv
// Directed bench for comparator_tpi_bist: functional path, control point,
// BIST run/restart/abort, async reset and (with SIG_SHIFT_EN) serial unload.
module tb_comparator_tpi_bist;

  logic        clk;
  logic        rst;
  logic [3:0]  a, b, c, d;
  logic        test_mode;
  logic [1:0]  tp_ctrl;
  logic        bist_start;
  logic        y;
  logic [1:0]  obs;
  logic        bist_busy;
  logic        bist_done;
  logic [15:0] signature;
  logic [7:0]  pattern_count;
`ifdef SIG_SHIFT_EN
  logic        sig_shift;
  logic        sig_so;
`endif

  int total;
  int bad;

  comparator_tpi_bist dut (
    .clk           (clk),
    .rst           (rst),
    .a             (a),
    .b             (b),
    .c             (c),
    .d             (d),
    .test_mode     (test_mode),
    .tp_ctrl       (tp_ctrl),
    .bist_start    (bist_start),
    .y             (y),
    .obs           (obs),
    .bist_busy     (bist_busy),
    .bist_done     (bist_done),
    .signature     (signature),
`ifdef SIG_SHIFT_EN
    .sig_shift     (sig_shift),
    .sig_so        (sig_so),
`endif
    .pattern_count (pattern_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: n patterns absorbed from seed/zero signature
  function automatic logic [15:0] model_sig(input int n);
    logic [15:0] l, s, r;
    logic [3:0]  ma, mb, mc, md;
    logic        gt, eq, ei, yc;
    l = 16'hACE1;
    s = 16'h0000;
    for (int k = 0; k < n; k++) begin
      ma = l[15:12];
      mb = l[11:8];
      mc = l[7:4];
      md = l[3:0];
      gt = ma > mb;
      eq = mc == md;
      ei = (k % 2 == 1) ? 1'b1 : eq;
      yc = gt & ei;
      r  = {12'h000, gt, eq, ei, yc};
      s  = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000) ^ r;
      l  = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    test_mode  = 1'b1;
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
  endtask

  // Waits for DONE and reports how many cycles busy was high
  task automatic wait_done(output int busy_cycles, output bit ok);
    busy_cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bist_busy) busy_cycles++;
      if (bist_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++;
    if ({y, obs, bist_busy, bist_done} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {y, obs, bist_busy, bist_done});
    end
    total++;
    if ({signature, pattern_count} !== 24'h0) begin
      bad++;
      $display("FAIL reset_regs got=%h want=000000",
               {signature, pattern_count});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_functional();
    test_mode = 1'b0;
    tp_ctrl = 2'b11;
    a = 4'd5; b = 4'd3; c = 4'd7; d = 4'd7;
    tick();
    total++;
    if ({y, obs} !== 3'b111) begin
      bad++;
      $display("FAIL func_gt_eq got=%b want=111", {y, obs});
    end
    d = 4'd6;
    tick();
    total++;
    if ({y, obs} !== 3'b010) begin
      bad++;
      $display("FAIL func_gt_ne got=%b want=010", {y, obs});
    end
    a = 4'd3; b = 4'd5; c = 4'd6;
    tick();
    total++;
    if ({y, obs} !== 3'b001) begin
      bad++;
      $display("FAIL func_lt_eq got=%b want=001", {y, obs});
    end
  endtask

  task automatic test_control_point();
    test_mode = 1'b1;
    tp_ctrl = 2'b11;
    a = 4'd5; b = 4'd3; c = 4'd1; d = 4'd2;
    tick();
    total++;
    if ({y, obs} !== 3'b110) begin
      bad++;
      $display("FAIL cp_force1 got=%b want=110", {y, obs});
    end
    tp_ctrl = 2'b10;
    a = 4'd9; b = 4'd2; c = 4'd4; d = 4'd4;
    tick();
    total++;
    if ({y, obs} !== 3'b011) begin
      bad++;
      $display("FAIL cp_force0 got=%b want=011", {y, obs});
    end
    tp_ctrl = 2'b01;
    tick();
    total++;
    if ({y, obs} !== 3'b111) begin
      bad++;
      $display("FAIL cp_free_eq got=%b want=111", {y, obs});
    end
    c = 4'd1; d = 4'd2;
    tick();
    total++;
    if ({y, obs} !== 3'b010) begin
      bad++;
      $display("FAIL cp_free_ne got=%b want=010", {y, obs});
    end
    tp_ctrl = 2'b00;
  endtask

  task automatic test_bist_run(input string tag);
    int  bc;
    bit  ok;
    logic [15:0] exp;
    exp = model_sig(255);
    pulse_start();
    wait_done(bc, ok);
    total++;
    if (!ok || bc != 255) begin
      bad++;
      $display("FAIL %s_busy got=%0d done=%0b want=255", tag, bc, ok);
    end
    total++;
    if (pattern_count !== 8'd255) begin
      bad++;
      $display("FAIL %s_count got=%0d want=255", tag, pattern_count);
    end
    total++;
    if (signature !== exp) begin
      bad++;
      $display("FAIL %s_sig got=%h want=%h", tag, signature, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    exp = model_sig(255);
    test_bist_run("run2");
    bist_start = 1'b1;
    test_mode  = 1'b0;
    tick();
    bist_start = 1'b0;
    total++;
    if (bist_done !== 1'b0 || signature !== exp) begin
      bad++;
      $display("FAIL done_exit got=%b/%h want=0/%h",
               bist_done, signature, exp);
    end
  endtask

  task automatic test_abort();
    logic [15:0] exp;
    exp = model_sig(40);
    pulse_start();
    repeat (40) tick();
    total++;
    if (pattern_count !== 8'd40 || bist_busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre got=%0d/%b want=40/1",
               pattern_count, bist_busy);
    end
    test_mode = 1'b0;
    tick();
    total++;
    if ({bist_busy, bist_done} !== 2'b00 || pattern_count !== 8'd40) begin
      bad++;
      $display("FAIL abort_state got=%b/%0d want=00/40",
               {bist_busy, bist_done}, pattern_count);
    end
    repeat (5) tick();
    total++;
    if (signature !== exp) begin
      bad++;
      $display("FAIL abort_sig got=%h want=%h", signature, exp);
    end
    pulse_start();
    total++;
    if (pattern_count !== 8'd0 || bist_busy !== 1'b1) begin
      bad++;
      $display("FAIL restart got=%0d/%b want=0/1",
               pattern_count, bist_busy);
    end
    tick();
    total++;
    if (pattern_count !== 8'd1) begin
      bad++;
      $display("FAIL restart_cnt got=%0d want=1", pattern_count);
    end
  endtask

  task automatic test_reset_mid_run();
    pulse_start();
    repeat (100) tick();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({y, obs, bist_busy, bist_done} !== 5'b0 ||
        {signature, pattern_count} !== 24'h0) begin
      bad++;
      $display("FAIL async_rst got=%b %h want=0 000000",
               {y, obs, bist_busy, bist_done},
               {signature, pattern_count});
    end
    @(negedge clk);
    rst = 1'b0;
    test_mode = 1'b0;
    tick();
    test_bist_run("post_rst");
  endtask

`ifdef SIG_SHIFT_EN
  task automatic test_sig_shift();
    logic [15:0] exp;
    int errs;
    exp  = model_sig(255);
    errs = 0;
    test_bist_run("pre_shift");
    sig_shift = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (sig_so !== exp[i]) errs++;
      tick();
    end
    sig_shift = 1'b0;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL sig_serial got=%0d bad_bits want=0", errs);
    end
    total++;
    if (signature !== 16'h0) begin
      bad++;
      $display("FAIL sig_empty got=%h want=0000", signature);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    test_mode = 1'b0;
    tp_ctrl = 2'b00;
    bist_start = 1'b0;
`ifdef SIG_SHIFT_EN
    sig_shift = 1'b0;
`endif
    test_reset();
    test_functional();
    test_control_point();
    test_bist_run("run1");
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
`ifdef SIG_SHIFT_EN
    test_sig_shift();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
